// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer and its bus neighbours.
package bus_timer_pkg;

  // Register offsets, selected by addr[3:2]
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int unsigned TC_EN_BIT   = 0;
  localparam int unsigned TC_MODE_LSB = 1;
  localparam int unsigned TC_MODE_MSB = 2;
  localparam int unsigned TC_IM_BIT   = 3;

  // Mode codes; 2'b1x behaves as one-shot
  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    TC_IDLE = 2'd0,
    TC_LOAD = 2'd1,
    TC_CNT  = 2'd2,
    TC_INT  = 2'd3
  } tc_state_e;

  // Replace only the byte lanes whose enable is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byteen);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byteen[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Countdown timer on the CPU data bus: CTRL/PRESET/COUNT registers, zero-latency
// reads, and an interrupt request gated by CTRL.IM.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        hit,
  output logic        irq
);

  tc_state_e   state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        int_flag_q, int_flag_d;

  logic [1:0]  offset;
  logic        wr_en;
  logic        wr_ctrl;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^m_data_addr[1:0];

  // Address decode and write strobes
  always_comb begin
    offset  = m_data_addr[3:2];
    hit     = (m_data_addr[31:4] == BASE_ADDR[31:4]) && (offset != 2'd3);
    wr_en   = hit && (|m_data_byteen);
    wr_ctrl = wr_en && (offset == TC_CTRL);
  end

  // Combinational read mux
  always_comb begin
    m_data_rdata = '0;
    if (hit) begin
      case (offset)
        TC_CTRL:   m_data_rdata = {28'd0, ctrl_q};
        TC_PRESET: m_data_rdata = preset_q;
        TC_COUNT:  m_data_rdata = count_q;
        default:   m_data_rdata = '0;
      endcase
    end
  end

  assign irq = ctrl_q[TC_IM_BIT] & int_flag_q;

  // Next-state: FSM, counter, flag, then bus writes layered on top
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    // Any CTRL write clears the flag; a same-edge hardware set below still wins
    int_flag_d = int_flag_q & ~wr_ctrl;

    case (state_q)
      TC_IDLE: begin
        if (ctrl_q[TC_EN_BIT]) state_d = TC_LOAD;
      end
      TC_LOAD: begin
        count_d = preset_q;
        state_d = TC_CNT;
      end
      TC_CNT: begin
        if (!ctrl_q[TC_EN_BIT]) begin
          state_d = TC_IDLE;
        end else if (count_q == '0) begin
          state_d    = TC_INT;
          int_flag_d = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      TC_INT: begin
        state_d = TC_IDLE;
        if (ctrl_q[TC_MODE_MSB:TC_MODE_LSB] == TC_MODE_RELOAD) begin
          int_flag_d = 1'b0;
        end else begin
          ctrl_d[TC_EN_BIT] = 1'b0;
        end
      end
      default: state_d = TC_IDLE;
    endcase

    // Bus value overrides the hardware EN clear on the same edge
    if (wr_ctrl && m_data_byteen[0]) ctrl_d = m_data_wdata[3:0];
    if (wr_en && (offset == TC_PRESET)) begin
      preset_d = byte_merge(preset_q, m_data_wdata, m_data_byteen);
    end
  end

  // State and register flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TC_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      int_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      int_flag_q <= int_flag_d;
    end
  end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped countdown timer that responds on the CPU data bus (m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata).
- Drives one interrupt line into the CPU's itr[5:0] vector.
- Sits behind the system bridge alongside DM; the bridge routes m_data_rdata back from whichever responder asserts hit.
- Two instances (Timer0/Timer1) are expected at different BASE_ADDR values.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window; bits [3:0] must be 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m_data_addr  input  32  byte address from the CPU M stage.
- m_data_wdata  input  32  write data, already lane-aligned.
- m_data_byteen  input  4  byte-lane write enables; 4'b0000 means read or no access.
- m_data_rdata  output  32  combinational read data for the addressed register; 0 when not hit.
- hit  output  1  m_data_addr falls inside this window at a mapped offset.
- irq  output  1  interrupt request: CTRL.IM & int_flag.

Behaviour:
- Register map (offset = addr[3:2]):
  - 0 = CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; [31:4] read 0.
  - 1 = PRESET, read/write.
  - 2 = COUNT, read-only.
  - 3 = unmapped.
- hit = (addr[31:4] == BASE_ADDR[31:4]) & (addr[3:2] != 3).
- Write strobe is hit & |byteen. Each lane i updates bits [8i+7:8i] only when byteen[i]=1. Writes to COUNT or unmapped offsets are ignored.
- Reads are zero latency (combinational), matching the M-stage sampling of m_data_rdata.
- Reset (reset=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, int_flag=0. Consequently irq=0 and m_data_rdata is a pure function of the inputs.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN goes to LOAD, else stays.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT: if !EN, go to IDLE (COUNT holds). Else if COUNT==0, go to INT and set int_flag<=1. Else COUNT<=COUNT-1.
  - INT: go to IDLE. In MODE 00, hardware clears EN on this edge. In MODE 01, EN stays set, so the timer reloads: period = PRESET+4 cycles.
- int_flag:
  - MODE 00: held until any bus write to CTRL clears it.
  - MODE 01: cleared on the edge leaving INT (one-cycle pulse).
- Timing from the edge that writes EN=1 with PRESET=P: irq rises after exactly P+3 further edges.
- Simultaneous events:
  - Bus write to CTRL on the same edge as the INT hardware EN-clear: the bus value wins. int_flag is still cleared by that write.
  - PRESET written during CNT does not affect the current count; it is used at the next LOAD.
  - EN cleared by the bus during LOAD or INT takes effect from the next state decision, with no spurious int_flag.
  - PRESET=0: LOAD then CNT sees COUNT==0 immediately, so INT follows in the next cycle.
- COUNT underflow is impossible: the decrement happens only when COUNT!=0.
- Reset asserted mid-count returns all state to reset values immediately (asynchronous).

Decomposition:
- Shared package holds:
  - register offsets TC_CTRL=2'd0, TC_PRESET=2'd1, TC_COUNT=2'd2;
  - CTRL bit positions (EN=0, MODE=2:1, IM=3);
  - mode codes TC_MODE_ONESHOT=2'b00, TC_MODE_RELOAD=2'b01;
  - state encoding TC_IDLE/TC_LOAD/TC_CNT/TC_INT.
- No sub-module. The FSM, registers and byte-lane merge form a single block; a byte-merge function may live in the package for reuse by the bridge and DM.

Test Plan:
- Reset check: assert reset=0 mid-simulation with EN=1 and COUNT=7 -> COUNT, CTRL, PRESET read 0, irq=0 before the next clk edge.
- One-shot: write PRESET=5, then CTRL=4'b1001 -> irq rises exactly 8 edges after the CTRL write and stays high; CTRL reads 4'b1000 (EN auto-cleared); writing CTRL=0 drops irq on the next edge.
- Auto-reload: PRESET=3, CTRL=4'b1011 -> irq is a one-cycle pulse every 7 cycles for at least 3 periods; COUNT sequence 3,2,1,0 repeats.
- Byte lanes: PRESET=32'h0, then write 32'hAABBCCDD with byteen=4'b0101 -> PRESET reads 32'h00BB00DD; write to COUNT offset -> COUNT unchanged.
- Disable mid-count: PRESET=10, enable, clear EN after 4 cycles -> state returns to IDLE, COUNT frozen at its current value, irq never rises.
- Address decode: access BASE_ADDR+12 and BASE_ADDR+16 -> hit=0, m_data_rdata=0, no register changes; BASE_ADDR+4 -> hit=1.
